// File: rtl/fpu_i2f_result_stage_pkg.sv
// Shared FPU definitions: fflags bit positions and the buffered int-to-float result entry.
package fpu_i2f_result_stage_pkg;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  // Entry fields are sized for the widest format; narrower formats zero-extend.
  localparam int FLEN_MAX = 32;
  localparam int TAG_MAX  = 8;

  typedef struct packed {
    logic [FLEN_MAX-1:0] fl;
    logic [TAG_MAX-1:0]  tag;
    logic                nv;
    logic                nx;
  } fpu_res_t;

  // Integer conversion can only raise NV or NX.
  function automatic logic [4:0] mk_flags(input logic nv, input logic nx);
    logic [4:0] f;
    f        = '0;
    f[FF_NV] = nv;
    f[FF_DZ] = 1'b0;
    f[FF_OF] = 1'b0;
    f[FF_UF] = 1'b0;
    f[FF_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fpu_i2f_result_stage_if.sv
// Converter-side push, writeback-side pop and CSR fflags signals of the i2f result stage.
interface fpu_i2f_result_stage_if #(
  parameter int STD   = 31,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [STD:0]     in_float;
  logic             in_nv;
  logic             in_nx;
  logic [TAG_W-1:0] in_tag;
  logic             wb_valid;
  logic             wb_ready;
  logic [STD:0]     wb_float;
  logic [TAG_W-1:0] wb_tag;
  logic [4:0]       wb_flags;
  logic             csr_we;
  logic [4:0]       csr_wdata;
  logic [4:0]       fflags;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_float, in_nv, in_nx, in_tag, wb_ready, csr_we, csr_wdata,
    input  in_ready, wb_valid, wb_float, wb_tag, wb_flags, fflags, count
  );

  modport slave (
    input  in_valid, in_float, in_nv, in_nx, in_tag, wb_ready, csr_we, csr_wdata,
    output in_ready, wb_valid, wb_float, wb_tag, wb_flags, fflags, count
  );

endinterface

// File: rtl/fpu_i2f_result_stage_fifo.sv
// Generic power-of-two FIFO; push refused when full, pop ignored when empty, no pass-through.
module fpu_result_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_i2f_result_stage.sv
// Buffers int-to-float results toward writeback and accrues sticky fflags on accept.
module fpu_i2f_result_stage
  import fpu_i2f_result_stage_pkg::*;
#(
  parameter int STD   = 31,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic                   clk,
  input logic                   rst,
  fpu_i2f_result_stage_if.slave io
);

  localparam int CW = $clog2(DEPTH) + 1;

  fpu_res_t      in_ent, head;
  logic          full, empty, push, pop;
  logic [CW-1:0] cnt;
  logic [4:0]    fflags_q, fflags_d;
  logic          unused_head;

  assign in_ent = '{fl: FLEN_MAX'(io.in_float), tag: TAG_MAX'(io.in_tag),
                    nv: io.in_nv, nx: io.in_nx};

  assign push = io.in_valid & ~full;
  assign pop  = io.wb_ready & ~empty;

  fpu_result_fifo #(
    .WIDTH ($bits(fpu_res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_ent),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  assign io.in_ready = ~full;
  assign io.wb_valid = ~empty;
  assign io.wb_float = head.fl[STD:0];
  assign io.wb_tag   = head.tag[TAG_W-1:0];
  assign io.wb_flags = mk_flags(head.nv, head.nx);
  assign io.count    = cnt;
  assign io.fflags   = fflags_q;
  // Zero-extension bits of narrow formats are never read back.
  assign unused_head = ^head;

  // A CSR write replaces the accrued value but still merges a same-cycle push.
  always_comb begin
    fflags_d = fflags_q;
    if (io.csr_we) fflags_d = io.csr_wdata;
    if (push)      fflags_d = fflags_d | mk_flags(io.in_nv, io.in_nx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fflags_q <= '0;
    else     fflags_q <= fflags_d;
  end

endmodule

// File: tb/tb_fpu_i2f_result_stage.sv
// Directed checks of the i2f result stage: buffering, backpressure, fflags accrual, async reset.
module tb_fpu_i2f_result_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fpu_i2f_result_stage_if #(.STD(31), .TAG_W(5), .DEPTH(2)) bus ();

  fpu_i2f_result_stage #(.STD(31), .DEPTH(2), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tg, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] f, input logic [4:0] t,
                       input logic nv, input logic nx);
    bus.in_valid = v;
    bus.in_float = f;
    bus.in_tag   = t;
    bus.in_nv    = nv;
    bus.in_nx    = nx;
  endtask

  initial begin
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.wb_ready  = 1'b0;
    bus.csr_we    = 1'b0;
    bus.csr_wdata = 5'h00;
    tick();
    tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wbv", 32'(bus.wb_valid), 32'd0);
    chk("rst_inrdy", 32'(bus.in_ready), 32'd1);
    chk("rst_ff", 32'(bus.fflags), 32'h00);

    // first edge after reset release accepts the push
    rst = 1'b0;
    drive(1'b1, 32'h3F800000, 5'd3, 1'b0, 1'b0);
    bus.wb_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("b1_wbv", 32'(bus.wb_valid), 32'd1);
    chk("b1_float", bus.wb_float, 32'h3F800000);
    chk("b1_tag", 32'(bus.wb_tag), 32'd3);
    chk("b1_flags", 32'(bus.wb_flags), 32'h00);
    tick();
    chk("b1_cnt0", 32'(bus.count), 32'd0);
    chk("b1_wbv0", 32'(bus.wb_valid), 32'd0);

    // backpressure: A, B fill the buffer; C (nv=1) held upstream
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'h40000000, 5'd10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h40400000, 5'd11, 1'b0, 1'b0);
    tick();
    chk("bp_cnt2", 32'(bus.count), 32'd2);
    chk("bp_rdy0", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h40800000, 5'd12, 1'b1, 1'b0);
    tick();
    chk("bp_cnt_hold", 32'(bus.count), 32'd2);
    chk("bp_head_a", 32'(bus.wb_tag), 32'd10);
    chk("bp_ff_ign", 32'(bus.fflags), 32'h00);
    bus.wb_ready = 1'b1;
    tick();
    chk("bp_pop_a_cnt", 32'(bus.count), 32'd1);
    chk("bp_head_b", 32'(bus.wb_tag), 32'd11);
    chk("bp_ff_nopush", 32'(bus.fflags), 32'h00);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("bp_c_cnt", 32'(bus.count), 32'd1);
    chk("bp_head_c", 32'(bus.wb_tag), 32'd12);
    chk("bp_c_float", bus.wb_float, 32'h40800000);
    chk("bp_c_flags", 32'(bus.wb_flags), 32'h10);
    chk("bp_ff_nv", 32'(bus.fflags), 32'h10);
    tick();
    chk("bp_empty", 32'(bus.count), 32'd0);

    // clear, then sticky NX survives pop and a clean push
    bus.csr_we    = 1'b1;
    bus.csr_wdata = 5'h00;
    tick();
    bus.csr_we = 1'b0;
    chk("ff_clr1", 32'(bus.fflags), 32'h00);
    drive(1'b1, 32'h3F000000, 5'd1, 1'b0, 1'b1);
    tick();
    chk("nx_flags", 32'(bus.wb_flags), 32'h01);
    chk("nx_ff", 32'(bus.fflags), 32'h01);
    drive(1'b1, 32'h3E800000, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("nx_sticky", 32'(bus.fflags), 32'h01);
    chk("nx_head2", 32'(bus.wb_tag), 32'd2);
    chk("nx_clean", 32'(bus.wb_flags), 32'h00);
    tick();
    bus.csr_we    = 1'b1;
    bus.csr_wdata = 5'h00;
    tick();
    bus.csr_we = 1'b0;
    chk("ff_clr2", 32'(bus.fflags), 32'h00);

    // CSR write merged with same-cycle push
    bus.csr_we    = 1'b1;
    bus.csr_wdata = 5'h04;
    drive(1'b1, 32'h3F800000, 5'd4, 1'b0, 1'b1);
    tick();
    bus.csr_we = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("csr_merge", 32'(bus.fflags), 32'h05);
    tick();
    chk("csr_drain", 32'(bus.count), 32'd0);

    // async reset mid-cycle with a full buffer
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'h41000000, 5'd5, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h41100000, 5'd6, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("ar_pre_cnt", 32'(bus.count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_wbv", 32'(bus.wb_valid), 32'd0);
    chk("ar_cnt", 32'(bus.count), 32'd0);
    chk("ar_ff", 32'(bus.fflags), 32'h00);
    chk("ar_rdy", 32'(bus.in_ready), 32'd1);
    #1 rst = 1'b0;
    drive(1'b1, 32'h41200000, 5'd7, 1'b0, 1'b0);
    tick();
    chk("ar_first_cnt", 32'(bus.count), 32'd1);
    chk("ar_first_tag", 32'(bus.wb_tag), 32'd7);

    // steady push+pop with count=1 across pointer wrap
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h3F800000 + 32'(i), 5'(8 + i), 1'b0, 1'b0);
      chk("ss_head", 32'(bus.wb_tag), 32'(7 + i));
      tick();
      chk("ss_cnt", 32'(bus.count), 32'd1);
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("ss_last", 32'(bus.wb_tag), 32'd17);
    chk("ss_last_f", bus.wb_float, 32'h3F800009);
    tick();
    chk("ss_drain", 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_i2f_result_stage.md
FPU_I2F_RESULT_STAGE -- requirements
Module: fpu_i2f_result_stage

Interface
REQ-001 Parameter STD, default 31: MSB index of the float result (31 = IEEE32, 15 = IEEE16/BF16).
REQ-002 Parameter DEPTH, default 2: result buffer entries, power of two, minimum 2.
REQ-003 Parameter TAG_W, default 5: width of the destination register tag.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port in_valid, input, 1: converter result is present this cycle.
REQ-007 Port in_ready, output, 1: stage can accept a result.
REQ-008 Port in_float, input, STD+1: converted float from the int-to-float converter.
REQ-009 Port in_nv, input, 1: converter invalid flag.
REQ-010 Port in_nx, input, 1: converter inexact flag.
REQ-011 Port in_tag, input, TAG_W: destination register tag.
REQ-012 Port wb_valid, output, 1: head entry valid toward writeback.
REQ-013 Port wb_ready, input, 1: writeback accepts the head entry.
REQ-014 Port wb_float, output, STD+1: head entry float.
REQ-015 Port wb_tag, output, TAG_W: head entry tag.
REQ-016 Port wb_flags, output, 5: head entry flags {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.
REQ-017 Port csr_we, input, 1: software write to the accrued fflags.
REQ-018 Port csr_wdata, input, 5: value written to the accrued fflags.
REQ-019 Port fflags, output, 5: accrued sticky exception flags.
REQ-020 Port count, output, log2(DEPTH)+1: current occupancy.

Function
REQ-021 Push occurs when in_valid & in_ready; the stage SHALL store {in_float, in_tag, in_nv, in_nx} at the tail entry.
REQ-022 Pop occurs when wb_valid & wb_ready; the stage SHALL advance the head pointer.
REQ-023 in_ready SHALL equal (count < DEPTH); there is no pass-through when full, so a push is refused while full even if a pop happens that cycle.
REQ-024 wb_valid SHALL equal (count != 0); wb_float, wb_tag and wb_flags SHALL be driven combinationally from the head entry, giving one-cycle latency from push to wb_valid.
REQ-025 Simultaneous push and pop while 0 < count < DEPTH SHALL leave count unchanged; push alone increments count and pop alone decrements it.
REQ-026 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH without any special case.
REQ-027 While wb_valid is high and wb_ready is low, the wb_* outputs SHALL hold stable.
REQ-028 The sticky flags update SHALL take effect on push, not on pop: fflags[4] |= in_nv and fflags[0] |= in_nx.
REQ-029 If csr_we and a push occur in the same cycle, fflags SHALL become csr_wdata OR the pushed flags.
REQ-030 csr_we alone SHALL load csr_wdata; fflags bits 3:1 SHALL be writable only by csr_we.
REQ-031 in_valid while in_ready is low SHALL be ignored, with no state or flag change; the upstream block holds the data.
REQ-032 Entry storage contents are don't-care when an entry is not occupied; wb_* outputs while wb_valid is low are don't-care.

Reset
REQ-033 Asserting rst SHALL immediately clear count, both pointers and fflags to 0, making wb_valid 0 and in_ready 1.
REQ-034 Reset mid-operation SHALL discard all buffered entries; entry storage need not be reset.
REQ-035 The first push SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-036 The shared FPU package SHALL hold the fflags bit-index constants (NV=4, DZ=3, OF=2, UF=1, NX=0) and the result-entry typedef {float, tag, nv, nx}.
REQ-037 The buffer SHALL be one sub-module, fpu_result_fifo, parameterized by width and DEPTH; flag accrual stays in the top module.

Verification
REQ-038 Reset, then push 0x3F800000 tag 3 with nx=0 and wb_ready=1 -> next cycle wb_valid=1, wb_float=0x3F800000, wb_tag=3, wb_flags=0; the following cycle count=0.
REQ-039 With wb_ready=0, push three results -> first two accepted, in_ready=0 after the second, the third is held upstream; raise wb_ready -> entries drain in order and the third is accepted only once count < 2.
REQ-040 Push a result with nx=1, pop it, then push a result with nx=0 -> fflags stays 0x01; csr_we with 0x00 -> fflags=0x00.
REQ-041 Same cycle csr_we=1 with csr_wdata=0x04 and a push with nx=1 -> fflags=0x05.
REQ-042 Assert rst asynchronously with count=2 mid-cycle -> wb_valid=0, count=0 and fflags=0 before the next clk edge.
REQ-043 Continuous push and pop every cycle for 10 cycles with count=1 -> count stays 1 and tags emerge in FIFO order across pointer wrap.
